// File: rtl/sipo_rx_if.sv
`default_nettype none
// ============================================================================
//  Module   : sipo_rx_if
//  Purpose  : Serial framing inputs and parallel word outputs of sipo_rx.
//             The master drives the serial side; the slave (the
//             deserialiser) returns the assembled word and status.
//  Revision : 1.0  initial release
// ============================================================================
interface sipo_rx_if #(
  parameter int N = 8
);
  logic         START;
  logic         SER_EN;
  logic         SER_IN;
  logic [N-1:0] PAR_OUT;
  logic         VALID;
  logic         BUSY;
  logic         ERR;

  modport master (
    output START, SER_EN, SER_IN,
    input  PAR_OUT, VALID, BUSY, ERR
  );

  modport slave (
    input  START, SER_EN, SER_IN,
    output PAR_OUT, VALID, BUSY, ERR
  );
endinterface
`default_nettype wire

// File: rtl/sipo_rx.sv
`default_nettype none
// ============================================================================
//  Module   : sipo_rx
//  Purpose  : Serial-in/parallel-out deserialiser. Frames begin with START,
//             bits are accepted on SER_EN, and the completed N-bit word is
//             presented on PAR_OUT with a one-cycle VALID pulse.
//  Revision : 1.0  initial release
// ============================================================================
module sipo_rx #(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  wire       CLK,
  input  wire       n_Reset,
  sipo_rx_if.slave  bus
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] c_LAST = CW'(N - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_sreg;
  logic [N-1:0]  r_par_out;
  logic          r_valid;
  logic          r_err;
  logic [N-1:0]  w_sreg_next;
  logic          w_last_bit;

  // Shift direction chosen at elaboration time.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_sreg_next = {r_sreg[N-2:0], bus.SER_IN};
    end else begin : g_lsb_first
      assign w_sreg_next = {bus.SER_IN, r_sreg[N-1:1]};
    end
  endgenerate

  assign w_last_bit = bus.SER_EN && (r_cnt == c_LAST);

  // Frame sequencer: completion takes priority over a coincident START,
  // which then simply re-arms the next frame without an idle cycle.
  always_ff @(posedge CLK or negedge n_Reset) begin
    if (!n_Reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_sreg    <= '0;
      r_par_out <= '0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.START) begin
            r_state <= S_SHIFT;
            r_cnt   <= '0;
            r_sreg  <= '0;
          end
        end
        S_SHIFT: begin
          if (w_last_bit) begin
            r_par_out <= w_sreg_next;
            r_valid   <= 1'b1;
            r_cnt     <= '0;
            r_sreg    <= '0;
            r_state   <= bus.START ? S_SHIFT : S_IDLE;
          end else if (bus.START) begin
            // Abort the partial word; any bit offered this edge is dropped.
            r_cnt  <= '0;
            r_sreg <= '0;
            r_err  <= 1'b1;
          end else if (bus.SER_EN) begin
            r_sreg <= w_sreg_next;
            r_cnt  <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_sreg  <= '0;
        end
      endcase
    end
  end

  assign bus.PAR_OUT = r_par_out;
  assign bus.VALID   = r_valid;
  assign bus.ERR     = r_err;
  assign bus.BUSY    = (r_state == S_SHIFT);

endmodule
`default_nettype wire

// File: tb/tb_sipo_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sipo_rx
//  Purpose  : Directed self-checking bench for sipo_rx: MSB-first N=8,
//             LSB-first N=8 and LSB-first N=4 instances.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sipo_rx;

  logic CLK;
  logic n_Reset;
  int   n_assert;
  int   n_fail;

  sipo_rx_if #(.N(8)) bus_a ();
  sipo_rx_if #(.N(8)) bus_b ();
  sipo_rx_if #(.N(4)) bus_c ();

  sipo_rx #(.N(8), .MSB_FIRST(1'b1)) u_a (.CLK(CLK), .n_Reset(n_Reset), .bus(bus_a));
  sipo_rx #(.N(8), .MSB_FIRST(1'b0)) u_b (.CLK(CLK), .n_Reset(n_Reset), .bus(bus_b));
  sipo_rx #(.N(4), .MSB_FIRST(1'b0)) u_c (.CLK(CLK), .n_Reset(n_Reset), .bus(bus_c));

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drv_a(input logic st, input logic en, input logic si);
    bus_a.START  = st;
    bus_a.SER_EN = en;
    bus_a.SER_IN = si;
  endtask

  // Send one MSB-first word on instance A with optional SER_EN gaps.
  // Counts VALID / BUSY / ERR cycles and PAR_OUT changes over the frame.
  task automatic frame_a(input logic [7:0] w, input int gap, input bit do_start,
                         output int vcnt, output int bcnt, output int ecnt, output int pchg);
    logic [7:0] prev;
    vcnt = 0; bcnt = 0; ecnt = 0; pchg = 0;
    prev = bus_a.PAR_OUT;
    if (do_start) begin
      drv_a(1'b1, 1'b1, 1'b1);
      tick();
      bcnt += int'(bus_a.BUSY); vcnt += int'(bus_a.VALID); ecnt += int'(bus_a.ERR);
    end
    for (int i = 7; i >= 0; i--) begin
      drv_a(1'b0, 1'b1, w[i]);
      tick();
      bcnt += int'(bus_a.BUSY); vcnt += int'(bus_a.VALID); ecnt += int'(bus_a.ERR);
      if (bus_a.PAR_OUT !== prev) pchg++;
      prev = bus_a.PAR_OUT;
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          drv_a(1'b0, 1'b0, ~w[i]);
          tick();
          bcnt += int'(bus_a.BUSY); vcnt += int'(bus_a.VALID); ecnt += int'(bus_a.ERR);
          if (bus_a.PAR_OUT !== prev) pchg++;
          prev = bus_a.PAR_OUT;
        end
      end
    end
    drv_a(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int vc, bc, ec, pc;
    logic [7:0] seq_b;
    logic [3:0] seq_c;
    n_assert = 0;
    n_fail   = 0;
    n_Reset  = 1'b0;
    drv_a(1'b0, 1'b0, 1'b0);
    bus_b.START = 1'b0; bus_b.SER_EN = 1'b0; bus_b.SER_IN = 1'b0;
    bus_c.START = 1'b0; bus_c.SER_EN = 1'b0; bus_c.SER_IN = 1'b0;
    tick();
    tick();
    chk("reset_par_a", bus_a.PAR_OUT, 32'h0);
    chk("reset_valid_a", bus_a.VALID, 32'h0);
    chk("reset_busy_a", bus_a.BUSY, 32'h0);
    chk("reset_err_a", bus_a.ERR, 32'h0);
    chk("reset_par_c", bus_c.PAR_OUT, 32'h0);
    n_Reset = 1'b1;

    // IDLE ignores serial bits
    drv_a(1'b0, 1'b1, 1'b1);
    tick();
    chk("idle_ignore_busy", bus_a.BUSY, 32'h0);
    chk("idle_ignore_valid", bus_a.VALID, 32'h0);

    // 1: back-to-back bits of A5
    drv_a(1'b0, 1'b0, 1'b0);
    frame_a(8'hA5, 0, 1'b1, vc, bc, ec, pc);
    chk("s1_valid_now", bus_a.VALID, 32'h1);
    chk("s1_par", bus_a.PAR_OUT, 32'hA5);
    chk("s1_busy_after", bus_a.BUSY, 32'h0);
    chk("s1_busy_cycles", bc, 32'd8);
    chk("s1_valid_count", vc, 32'd1);
    tick();
    chk("s1_valid_drop", bus_a.VALID, 32'h0);
    chk("s1_par_hold", bus_a.PAR_OUT, 32'hA5);

    // 2: same word with two-cycle gaps
    frame_a(8'hA5, 2, 1'b1, vc, bc, ec, pc);
    chk("s2_par", bus_a.PAR_OUT, 32'hA5);
    chk("s2_busy_cycles", bc, 32'd22);
    chk("s2_valid_count", vc, 32'd1);
    tick();

    // 3: abort after 3 bits, then 3C
    drv_a(1'b1, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drv_a(1'b0, 1'b1, 1'b1);
      tick();
    end
    drv_a(1'b1, 1'b1, 1'b1);
    tick();
    chk("s3_err", bus_a.ERR, 32'h1);
    chk("s3_err_novalid", bus_a.VALID, 32'h0);
    chk("s3_err_busy", bus_a.BUSY, 32'h1);
    chk("s3_par_held", bus_a.PAR_OUT, 32'hA5);
    frame_a(8'h3C, 0, 1'b0, vc, bc, ec, pc);
    chk("s3_par", bus_a.PAR_OUT, 32'h3C);
    chk("s3_valid_count", vc, 32'd1);
    chk("s3_err_count", ec, 32'd0);
    chk("s3_par_changes", pc, 32'd1);
    tick();
    chk("s3_err_pulse_gone", bus_a.ERR, 32'h0);

    // 4: START with the final bit of FF, then 01 with no further START
    drv_a(1'b1, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 7; i++) begin
      drv_a(1'b0, 1'b1, 1'b1);
      tick();
    end
    drv_a(1'b1, 1'b1, 1'b1);
    tick();
    chk("s4_valid1", bus_a.VALID, 32'h1);
    chk("s4_par1", bus_a.PAR_OUT, 32'hFF);
    chk("s4_busy_kept", bus_a.BUSY, 32'h1);
    chk("s4_no_err1", bus_a.ERR, 32'h0);
    frame_a(8'h01, 0, 1'b0, vc, bc, ec, pc);
    chk("s4_par2", bus_a.PAR_OUT, 32'h01);
    chk("s4_valid_count2", vc, 32'd1);
    chk("s4_err_count2", ec, 32'd0);
    chk("s4_busy_cycles2", bc, 32'd7);
    tick();

    // 5: async reset mid-frame
    frame_a(8'h5A, 0, 1'b1, vc, bc, ec, pc);
    chk("s5_par", bus_a.PAR_OUT, 32'h5A);
    tick();
    drv_a(1'b1, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drv_a(1'b0, 1'b1, 1'b1);
      tick();
    end
    #2;
    n_Reset = 1'b0;
    #1;
    chk("s5_rst_par", bus_a.PAR_OUT, 32'h0);
    chk("s5_rst_busy", bus_a.BUSY, 32'h0);
    chk("s5_rst_valid", bus_a.VALID, 32'h0);
    tick();
    n_Reset = 1'b1;
    vc = 0; bc = 0; ec = 0;
    for (int i = 0; i < 10; i++) begin
      drv_a(1'b0, 1'b1, 1'b1);
      tick();
      vc += int'(bus_a.VALID); bc += int'(bus_a.BUSY); ec += int'(bus_a.ERR);
    end
    chk("s5_idle_valid", vc, 32'd0);
    chk("s5_idle_busy", bc, 32'd0);
    chk("s5_idle_err", ec, 32'd0);
    chk("s5_idle_par", bus_a.PAR_OUT, 32'h0);
    drv_a(1'b0, 1'b0, 1'b0);
    frame_a(8'hC3, 0, 1'b1, vc, bc, ec, pc);
    chk("s5_after_par", bus_a.PAR_OUT, 32'hC3);

    // 6a: LSB-first N=8, bits 1,0,1,0,0,1,0,1 in send order
    seq_b = 8'b1010_0101;
    bus_b.START = 1'b1;
    tick();
    bus_b.START = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus_b.SER_EN = 1'b1;
      bus_b.SER_IN = seq_b[i];
      tick();
    end
    bus_b.SER_EN = 1'b0;
    chk("s6_lsb8_par", bus_b.PAR_OUT, 32'hA5);
    chk("s6_lsb8_valid", bus_b.VALID, 32'h1);

    // 6b: LSB-first N=4, bits 1,1,0,0 in send order
    seq_c = 4'b0011;
    bus_c.START = 1'b1;
    tick();
    bus_c.START = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus_c.SER_EN = 1'b1;
      bus_c.SER_IN = seq_c[i];
      tick();
      if (i < 3) chk("s6_n4_no_early_valid", bus_c.VALID, 32'h0);
    end
    bus_c.SER_EN = 1'b0;
    chk("s6_n4_par", bus_c.PAR_OUT, 32'h3);
    chk("s6_n4_valid", bus_c.VALID, 32'h1);
    chk("s6_n4_busy", bus_c.BUSY, 32'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sipo_rx.md
Name: sipo_rx

Overview:
Serial-in/parallel-out deserialiser. It assembles a framed bit stream into an N-bit word. It sits directly upstream of the N-bit enabled holding register: PAR_OUT drives the register's D input, and VALID drives its EN. Framing is set by a START strobe and per-bit SER_EN qualifiers, so bit gaps are tolerated.

Parameters:
N, 8, word width in bits; legal range 2..32.
MSB_FIRST, 1, 1 = first received bit lands in PAR_OUT[N-1]; 0 = first bit lands in PAR_OUT[0].

Ports:
CLK  input  1  system clock; all state changes on the rising edge.
n_Reset  input  1  asynchronous, active-low reset.
START  input  1  frame start strobe, sampled on the rising edge of CLK.
SER_EN  input  1  bit qualifier: SER_IN is accepted on the edge where SER_EN=1.
SER_IN  input  1  serial data bit.
PAR_OUT  output  N  last completed word; holds between frames.
VALID  output  1  one-cycle pulse: PAR_OUT has just been updated.
BUSY  output  1  high while a frame is being shifted (state SHIFT).
ERR  output  1  one-cycle pulse: a partial frame was aborted by START.

Behaviour:
- Reset (n_Reset=0, asynchronous, takes precedence over everything):
  - state=IDLE, bit counter=0, shift register=0
  - PAR_OUT=0, VALID=0, BUSY=0, ERR=0
- States: IDLE, SHIFT. BUSY is 1 exactly when state=SHIFT and is registered.
- IDLE:
  - SER_EN and SER_IN are ignored.
  - START=1 -> SHIFT, counter=0, shift register cleared.
  - The START cycle never samples a bit, even if SER_EN=1.
- SHIFT, SER_EN=1, START=0:
  - Shift SER_IN in. MSB_FIRST=1: sreg <= {sreg[N-2:0], SER_IN}. MSB_FIRST=0: sreg <= {SER_IN, sreg[N-1:1]}.
  - Counter increments.
- SHIFT, SER_EN=0, START=0: hold everything. No timeout.
- Completion: on the edge that accepts bit N (counter==N-1 and SER_EN=1):
  - PAR_OUT <= assembled word, including this bit.
  - VALID=1 for the following cycle only.
  - state -> IDLE, counter -> 0.
  - Latency: VALID rises at the same edge that accepts the last bit, so the downstream register captures on the next edge.
- START during SHIFT with counter>0, or with counter==0 after START has already been seen:
  - Partial word discarded, counter=0, stay in SHIFT.
  - ERR=1 for one cycle. PAR_OUT unchanged, no VALID.
  - Simultaneous SER_EN on that edge is ignored.
- START on the same edge as the final bit:
  - Word completes normally (VALID=1, PAR_OUT updated, ERR=0).
  - A new frame is armed: state stays SHIFT, counter=0.
  - This gives back-to-back frames with no idle cycle.
- VALID and ERR are never both 1 on the same cycle.
- PAR_OUT changes only on a completion edge or on reset.
- Counter width is clog2(N). It never exceeds N-1 and does not wrap; completion always returns it to 0.
- Reset mid-frame: the partial word is lost and PAR_OUT is cleared to 0. No VALID or ERR is generated on reset release.

Test Plan:
1. N=8, MSB_FIRST=1: START, then 8 consecutive SER_EN bits 1,0,1,0,0,1,0,1 -> PAR_OUT=8'hA5, VALID high exactly one cycle after the 8th bit edge, BUSY high 8 cycles.
2. N=8, MSB_FIRST=1, same bits as scenario 1 with 2-cycle SER_EN=0 gaps between bits -> PAR_OUT=8'hA5, BUSY stays high through the gaps, single VALID pulse.
3. N=8: START, 3 bits, START again, then 8 bits of 8'h3C -> ERR one cycle at the 2nd START, PAR_OUT=8'h3C, one VALID, no intermediate PAR_OUT change.
4. N=8: START asserted together with the 8th bit of 8'hFF, then 8 bits of 8'h01 -> VALID with PAR_OUT=8'hFF, BUSY stays 1, then VALID with PAR_OUT=8'h01, ERR never asserted.
5. N=8: complete 8'h5A, start a new frame, drop n_Reset asynchronously mid-clock after 4 bits -> PAR_OUT=0, BUSY=0, VALID=0 immediately; after release, IDLE ignores SER_EN until START.
6. N=8, MSB_FIRST=0, bits 1,0,1,0,0,1,0,1 -> PAR_OUT=8'hA5 (bit0 first). Repeat with N=4 and bits 1,1,0,0 -> PAR_OUT=4'h3.
